// File: rtl/rca_pkg.sv
// Shared types for the RCA result path; sums up to RCA_DATA_W bits wide.
// Optional per-entry zero flag is enabled by RCA_RESULT_FIFO_ZERO_FLAG_EN.
package rca_pkg;

  localparam int RCA_DATA_W = 32;
  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic [RCA_DATA_W-1:0] sum;
    logic                  carry;
`ifdef RCA_RESULT_FIFO_ZERO_FLAG_EN
    logic                  zero;
`endif
  } rca_entry_t;

  function automatic rca_entry_t make_entry(input logic [RCA_DATA_W-1:0] sum,
                                            input logic                  carry);
    rca_entry_t e;
    e.sum   = sum;
    e.carry = carry;
`ifdef RCA_RESULT_FIFO_ZERO_FLAG_EN
    e.zero  = (sum == {RCA_DATA_W{1'b0}});
`endif
    return e;
  endfunction

endpackage

// File: rtl/rca_sat_cnt.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module rca_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: stop at the maximum value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rca_result_fifo.sv
// First-word fall-through FIFO for registered adder results, with saturating drop count.
// Optional zero-flag output out_z under RCA_RESULT_FIFO_ZERO_FLAG_EN.
module rca_result_fifo
  import rca_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = RCA_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_s,
  input  logic                       in_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_s,
  output logic                       out_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DROP_CNT_W-1:0]      drop_cnt
`ifdef RCA_RESULT_FIFO_ZERO_FLAG_EN
  ,
  output logic                       out_z
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s, drop_s, full_s, empty_s;
  rca_entry_t       wr_entry_s;
  rca_entry_t       head_s;
  rca_entry_t       mem_q [DEPTH];

  // Handshake decode: a full FIFO still accepts a push when the head leaves this cycle.
  always_comb begin
    full_s     = (count_q == CNT_W'(DEPTH));
    empty_s    = (count_q == {CNT_W{1'b0}});
    pop_s      = !empty_s && out_ready;
    push_s     = in_valid && (!full_s || pop_s);
    drop_s     = in_valid && full_s && !pop_s;
    wr_entry_s = make_entry(RCA_DATA_W'(in_s), in_c);
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  rca_sat_cnt #(.W(DROP_CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_s),
    .cnt   (drop_cnt)
  );

  assign head_s    = mem_q[rd_ptr_q];
  assign out_valid = !empty_s;
  assign out_s     = DATA_W'(head_s.sum);
  assign out_c     = head_s.carry;
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_q;
`ifdef RCA_RESULT_FIFO_ZERO_FLAG_EN
  assign out_z     = head_s.zero;
`endif

endmodule

// File: tb/tb_rca_result_fifo.sv
// Scoreboard bench for rca_result_fifo: queue reference model, negedge monitor.
`timescale 1ns/1ps
module tb_rca_result_fifo;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_s;
  logic              in_c;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_s;
  logic              out_c;
  logic              full;
  logic              empty;
  logic [2:0]        count;
  logic [7:0]        drop_cnt;
`ifdef RCA_RESULT_FIFO_ZERO_FLAG_EN
  logic              out_z;
`endif

  typedef struct {
    logic [DATA_W-1:0] s;
    logic              c;
  } exp_t;

  exp_t exp_q[$];
  int   model_drop    = 0;
  int   exp_count_now = 0;
  int   exp_drop_now  = 0;
  bit   mon_en        = 1'b0;
  int   checks        = 0;
  int   passed        = 0;

  always #5 clk = ~clk;

  rca_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_s      (in_s),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_cnt  (drop_cnt)
`ifdef RCA_RESULT_FIFO_ZERO_FLAG_EN
    ,
    .out_z     (out_z)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: compare status every cycle, head whenever valid, retire on handshake.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("count", 64'(count), 64'(exp_count_now));
      chk("empty", 64'(empty), 64'(exp_count_now == 0));
      chk("full", 64'(full), 64'(exp_count_now == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_count_now != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop_now));
      if (out_valid && exp_q.size() > 0) begin
        chk("out_s", 64'(out_s), 64'(exp_q[0].s));
        chk("out_c", 64'(out_c), 64'(exp_q[0].c));
`ifdef RCA_RESULT_FIFO_ZERO_FLAG_EN
        chk("out_z", 64'(out_z), 64'(exp_q[0].s == 32'd0));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One stimulus cycle: drive after the edge, update the reference model.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] s, input logic c, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    exp_count_now = exp_q.size();
    exp_drop_now  = model_drop;
    in_valid  = v;
    in_s      = s;
    in_c      = c;
    out_ready = r;
    if (v) begin
      if (exp_q.size() < DEPTH || r) begin
        e.s = s;
        e.c = c;
        exp_q.push_back(e);
      end else if (model_drop < 255) begin
        model_drop++;
      end
    end
  endtask

  task automatic drain();
    repeat (DEPTH + 1) cycle(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_s = 32'd0; in_c = 1'b0; out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single result with consumer stalled.
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    drain();

    // Fill to four, then drain in order.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'(i & 1), 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    drain();

    // Full: three drops, then three push-with-pop.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(16 * i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD_0000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    // Long drop burst saturates the counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    #1 chk("drop_sat", 64'(drop_cnt), 64'd255);
    drain();

    // Asynchronous reset in the middle of a cycle with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2 chk("pre_rst_count", 64'(count), 64'd3);
    #1 rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    model_drop = 0; exp_count_now = 0; exp_drop_now = 0;
    #1 check_reset_outputs("mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 32'h5, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    drain();

    // Zero and non-zero sums (zero flag checked when present).
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'd7, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom),
            1'($urandom_range(0, 1)));
    end
    drain();
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
